// File: rtl/ctrl_pkg.sv
// Shared types and constants for the retire-stage debug controller.
package ctrl_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular PC-history buffer; a push into a full buffer discards the oldest entry.
module pc_trace_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          full;
   logic          pop_ok;

   assign full   = (level == (AW+1)'(DEPTH));
   assign empty  = (level == '0);
   assign pop_ok = pop && !empty;
   assign data   = mem[rptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
            // Full push always advances rptr: either the pop consumed the
            // oldest entry or the push overwrote it.
            if (full) begin
               rptr <= rptr + 1'b1;
               if (!pop_ok)
                  ovf <= 1'b1;
            end else if (pop_ok) begin
               rptr <= rptr + 1'b1;
            end else begin
               level <= level + 1'b1;
            end
         end else if (pop_ok) begin
            rptr  <= rptr + 1'b1;
            level <= level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_unit.sv
// Retire-stage debug controller: instruction counter, PC trace and breakpoint halt.
// rst_n is an active-high asynchronous reset despite its name.
module ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned NUM_BP      = 4,
   parameter int unsigned TRACE_DEPTH = 16
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [XLEN-1:0]                            pc,
   input  logic                                       valid,
   input  logic                                       bp_we,
   input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_idx,
   input  logic [XLEN-1:0]                            bp_addr,
   input  logic                                       bp_en,
   input  logic                                       resume,
   input  logic                                       trace_rd,
   output logic                                       halt,
   output logic                                       hit,
   output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] hit_idx,
   output logic [XLEN-1:0]                            retired_cnt,
   output logic [XLEN-1:0]                            trace_data,
   output logic                                       trace_empty,
   output logic [$clog2(TRACE_DEPTH):0]               trace_level,
   output logic                                       trace_ovf
);

   localparam int unsigned IW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

   logic [XLEN-1:0]   bp_addr_q [NUM_BP];
   logic [NUM_BP-1:0] bp_en_q;
   state_t            state;
   logic              skip;
   logic [XLEN-1:0]   skip_pc;
   logic              accept;
   logic              match;
   logic [IW-1:0]     match_idx;
   logic              trigger;

   always_comb begin
      accept    = valid && (state == RUN);
      match     = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < NUM_BP; i++) begin
         if (!match && bp_en_q[i] && (bp_addr_q[i] == pc)) begin
            match     = 1'b1;
            match_idx = IW'(i);
         end
      end
      trigger = accept && match && !(skip && (pc == skip_pc));
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         bp_en_q <= '0;
         for (int unsigned i = 0; i < NUM_BP; i++)
            bp_addr_q[i] <= '0;
      end else if (bp_we && (32'(bp_idx) < NUM_BP)) begin
         bp_addr_q[bp_idx] <= bp_addr;
         bp_en_q[bp_idx]   <= bp_en;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= RUN;
         halt        <= 1'b0;
         hit         <= 1'b0;
         hit_idx     <= '0;
         retired_cnt <= '0;
         skip        <= 1'b0;
         skip_pc     <= '0;
      end else begin
         hit <= trigger;
         // Skip guard lives only until the first accepted pc after resume.
         if (accept) begin
            retired_cnt <= retired_cnt + 1'b1;
            skip        <= 1'b0;
         end
         case (state)
            RUN: begin
               if (trigger) begin
                  state   <= HALT;
                  halt    <= 1'b1;
                  hit_idx <= match_idx;
                  skip    <= 1'b1;
                  skip_pc <= pc;
               end
            end
            HALT: begin
               if (resume) begin
                  state <= RUN;
                  halt  <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   pc_trace_buf #(
      .DEPTH (TRACE_DEPTH),
      .W     (XLEN)
   ) u_trace (
      .clk       (clk),
      .rst       (rst_n),
      .push      (accept),
      .push_data (pc),
      .pop       (trace_rd),
      .data      (trace_data),
      .empty     (trace_empty),
      .level     (trace_level),
      .ovf       (trace_ovf)
   );

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit.
module tb_ctrl_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        valid;
   logic        bp_we;
   logic [1:0]  bp_idx;
   logic [31:0] bp_addr;
   logic        bp_en;
   logic        resume;
   logic        trace_rd;
   logic        halt;
   logic        hit;
   logic [1:0]  hit_idx;
   logic [31:0] retired_cnt;
   logic [31:0] trace_data;
   logic        trace_empty;
   logic [4:0]  trace_level;
   logic        trace_ovf;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];
   logic [31:0] oldest;

   ctrl_unit #(
      .NUM_BP      (4),
      .TRACE_DEPTH (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .valid       (valid),
      .bp_we       (bp_we),
      .bp_idx      (bp_idx),
      .bp_addr     (bp_addr),
      .bp_en       (bp_en),
      .resume      (resume),
      .trace_rd    (trace_rd),
      .halt        (halt),
      .hit         (hit),
      .hit_idx     (hit_idx),
      .retired_cnt (retired_cnt),
      .trace_data  (trace_data),
      .trace_empty (trace_empty),
      .trace_level (trace_level),
      .trace_ovf   (trace_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [31:0] p);
      if (exp_q.size() == 16)
         void'(exp_q.pop_front());
      exp_q.push_back(p);
   endtask

   // One valid retire cycle; acc says whether the controller should take it.
   task automatic drive(input logic [31:0] p, input bit acc);
      valid = 1'b1;
      pc    = p;
      if (acc)
         model_push(p);
      tick();
      valid = 1'b0;
   endtask

   task automatic write_bp(input logic [1:0] idx, input logic [31:0] a, input logic en);
      bp_we   = 1'b1;
      bp_idx  = idx;
      bp_addr = a;
      bp_en   = en;
      tick();
      bp_we   = 1'b0;
   endtask

   task automatic do_resume();
      resume = 1'b1;
      tick();
      resume = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && !trace_empty; i++) begin
         oldest = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check_eq("drain_data", trace_data, oldest);
         trace_rd = 1'b1;
         tick();
         trace_rd = 1'b0;
      end
      check_eq("drain_empty", {31'b0, trace_empty}, 32'd1);
      check_eq("drain_level", {27'b0, trace_level}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1; pc = '0; valid = 1'b0; bp_we = 1'b0; bp_idx = '0;
      bp_addr = '0; bp_en = 1'b0; resume = 1'b0; trace_rd = 1'b0;
      #100;
      check_eq("rst_halt",  {31'b0, halt}, 32'd0);
      check_eq("rst_hit",   {31'b0, hit}, 32'd0);
      check_eq("rst_idx",   {30'b0, hit_idx}, 32'd0);
      check_eq("rst_cnt",   retired_cnt, 32'd0);
      check_eq("rst_empty", {31'b0, trace_empty}, 32'd1);
      check_eq("rst_level", {27'b0, trace_level}, 32'd0);
      check_eq("rst_ovf",   {31'b0, trace_ovf}, 32'd0);
      rst_n = 1'b0;
      tick();

      // Pure tracing: 20 pcs into a 16-deep buffer.
      for (int n = 0; n < 20; n++) begin
         drive(32'(n * 8), 1'b1);
         check_eq("t1_no_halt", {31'b0, halt}, 32'd0);
      end
      check_eq("t1_cnt",   retired_cnt, 32'd20);
      check_eq("t1_level", {27'b0, trace_level}, 32'd16);
      check_eq("t1_ovf",   {31'b0, trace_ovf}, 32'd1);
      check_eq("t1_data",  trace_data, 32'h20);
      check_eq("t1_model", trace_data, exp_q[0]);

      // Breakpoint halt, ignored retires, resume and skip of the halting pc.
      write_bp(2'd0, 32'h40, 1'b1);
      drive(32'h38, 1'b1);
      check_eq("t2_cnt_a", retired_cnt, 32'd21);
      check_eq("t2_hit_pre", {31'b0, hit}, 32'd0);
      drive(32'h40, 1'b1);
      check_eq("t2_hit",  {31'b0, hit}, 32'd1);
      check_eq("t2_idx",  {30'b0, hit_idx}, 32'd0);
      check_eq("t2_halt", {31'b0, halt}, 32'd1);
      check_eq("t2_cnt_b", retired_cnt, 32'd22);
      drive(32'h48, 1'b0);
      check_eq("t2_hit_pulse", {31'b0, hit}, 32'd0);
      check_eq("t2_halt_hold", {31'b0, halt}, 32'd1);
      drive(32'h50, 1'b0);
      check_eq("t2_cnt_frozen", retired_cnt, 32'd22);
      do_resume();
      check_eq("t2_resumed", {31'b0, halt}, 32'd0);
      drive(32'h40, 1'b1);
      check_eq("t2_skip_hit",  {31'b0, hit}, 32'd0);
      check_eq("t2_skip_halt", {31'b0, halt}, 32'd0);
      check_eq("t2_cnt_c", retired_cnt, 32'd23);
      drive(32'h48, 1'b1);
      check_eq("t2_cnt_d", retired_cnt, 32'd24);
      drive(32'h40, 1'b1);
      check_eq("t2_rehit",  {31'b0, hit}, 32'd1);
      check_eq("t2_rehalt", {31'b0, halt}, 32'd1);
      do_resume();
      check_eq("t2_resumed2", {31'b0, halt}, 32'd0);
      do_resume();
      check_eq("t2_resume_in_run", {31'b0, halt}, 32'd0);

      // Two slots on the same pc: lowest index wins.
      write_bp(2'd1, 32'h80, 1'b1);
      write_bp(2'd2, 32'h80, 1'b1);
      drive(32'h80, 1'b1);
      check_eq("t3_hit",  {31'b0, hit}, 32'd1);
      check_eq("t3_idx",  {30'b0, hit_idx}, 32'd1);
      check_eq("t3_cnt",  retired_cnt, 32'd26);
      tick();
      check_eq("t3_idx_held", {30'b0, hit_idx}, 32'd1);
      do_resume();

      // Trace pops: drain, pop while pushing, pop on empty.
      drain();
      drive(32'h100, 1'b1);
      drive(32'h108, 1'b1);
      drive(32'h110, 1'b1);
      check_eq("t4_level3", {27'b0, trace_level}, 32'd3);
      for (int k = 0; k < 3; k++) begin
         check_eq("t4_pp_data", trace_data, exp_q[0]);
         void'(exp_q.pop_front());
         trace_rd = 1'b1;
         drive(32'h200 + 32'(k * 4), 1'b1);
         trace_rd = 1'b0;
         check_eq("t4_pp_level", {27'b0, trace_level}, 32'd3);
      end
      drain();
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
      check_eq("t4_empty_pop_level", {27'b0, trace_level}, 32'd0);
      check_eq("t4_empty_pop_empty", {31'b0, trace_empty}, 32'd1);

      // Slot write coinciding with a compare uses the old value.
      bp_we = 1'b1; bp_idx = 2'd0; bp_addr = 32'h10; bp_en = 1'b1;
      drive(32'h10, 1'b1);
      bp_we = 1'b0;
      check_eq("t6_no_hit",  {31'b0, hit}, 32'd0);
      check_eq("t6_no_halt", {31'b0, halt}, 32'd0);
      drive(32'h10, 1'b1);
      check_eq("t6_hit_next", {31'b0, hit}, 32'd1);
      check_eq("t6_halt_next", {31'b0, halt}, 32'd1);

      // Asynchronous reset while halted.
      rst_n = 1'b1;
      #2;
      check_eq("t5_halt",  {31'b0, halt}, 32'd0);
      check_eq("t5_hit",   {31'b0, hit}, 32'd0);
      check_eq("t5_cnt",   retired_cnt, 32'd0);
      check_eq("t5_empty", {31'b0, trace_empty}, 32'd1);
      check_eq("t5_level", {27'b0, trace_level}, 32'd0);
      check_eq("t5_ovf",   {31'b0, trace_ovf}, 32'd0);
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      drive(32'h10, 1'b1);
      check_eq("t5_bp_cleared_hit",  {31'b0, hit}, 32'd0);
      check_eq("t5_bp_cleared_halt", {31'b0, halt}, 32'd0);
      check_eq("t5_cnt_after", retired_cnt, 32'd1);
      check_eq("t5_trace_after", trace_data, 32'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
